// File: rtl/ofdm_sync_ctrl.sv
// Frame sequencer for the OFDM synchronizer core: validates/loads the symbol
// count, gates the core input stream, checks output frame length, keeps counters.
module ofdm_sync_ctrl #(
    parameter int MAX_NUM_SYMBOLS = 10,
    parameter int SYMBOL_LEN      = 64,
    parameter int TIMEOUT_W       = 24,
    parameter int CNT_W           = 16
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [$clog2(MAX_NUM_SYMBOLS+1)-1:0]   cfg_num_symbols,
    input  logic [TIMEOUT_W-1:0]                   cfg_timeout,
    input  logic                                   cfg_continuous,
    input  logic                                   arm,
    input  logic                                   abort,
    output logic [$clog2(MAX_NUM_SYMBOLS+1)-1:0]   sync_num_symbols,
    output logic                                   sync_num_symbols_valid,
    input  logic                                   s_tvalid,
    output logic                                   s_tready,
    output logic                                   m_tvalid,
    input  logic                                   m_tready,
    input  logic                                   mon_tvalid,
    input  logic                                   mon_tready,
    input  logic                                   mon_sof,
    input  logic                                   mon_eof,
    output logic                                   busy,
    output logic                                   frame_done,
    output logic                                   frame_err,
    output logic                                   timeout,
    output logic                                   cfg_err,
    output logic [CNT_W-1:0]                       frame_cnt,
    output logic [CNT_W-1:0]                       err_cnt
);

    localparam int NW = $clog2(MAX_NUM_SYMBOLS+1);
    localparam int SW = $clog2(MAX_NUM_SYMBOLS*SYMBOL_LEN+1);
    localparam logic [NW-1:0] MAX_NS  = NW'(MAX_NUM_SYMBOLS);
    localparam logic [SW-1:0] SMP_SAT = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIG,
        S_SEARCH,
        S_FRAME,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic                   r_gate;
    logic [NW-1:0]          r_nsym;
    logic                   r_nsym_vld;
    logic [SW-1:0]          r_len;
    logic [TIMEOUT_W-1:0]   r_timeout;
    logic                   r_cont;
    logic [TIMEOUT_W-1:0]   r_tmo_cnt;
    logic [SW-1:0]          r_smp_cnt;
    logic                   r_done;
    logic                   r_ferr;
    logic                   r_tmo;
    logic                   r_cerr;
    logic [CNT_W-1:0]       r_frame_cnt;
    logic [CNT_W-1:0]       r_err_cnt;

    logic                   w_beat;
    logic                   w_cfg_ok;
    logic                   w_tmo_hit;
    logic [SW-1:0]          w_smp_next;
    logic                   w_end;
    logic                   w_end_ok;

    assign w_beat     = mon_tvalid & mon_tready;
    assign w_cfg_ok   = (cfg_num_symbols != '0) && (cfg_num_symbols <= MAX_NS);
    assign w_tmo_hit  = (r_timeout != '0) && (r_tmo_cnt == (r_timeout - TIMEOUT_W'(1)));
    assign w_smp_next = (r_smp_cnt == SMP_SAT) ? SMP_SAT : (r_smp_cnt + SW'(1));

    // Frame end: SOF+EOF on one beat in SEARCH, EOF in FRAME, or overrun past L.
    always_comb begin
        w_end    = 1'b0;
        w_end_ok = 1'b0;
        if (r_state == S_SEARCH && w_beat && mon_sof && mon_eof) begin
            w_end    = 1'b1;
            w_end_ok = (r_len == SW'(1));
        end else if (r_state == S_FRAME && w_beat) begin
            if (mon_eof) begin
                w_end    = 1'b1;
                w_end_ok = (w_smp_next == r_len);
            end else if (w_smp_next > r_len) begin
                w_end    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_gate      <= 1'b0;
            r_nsym      <= '0;
            r_nsym_vld  <= 1'b0;
            r_len       <= '0;
            r_timeout   <= '0;
            r_cont      <= 1'b0;
            r_tmo_cnt   <= '0;
            r_smp_cnt   <= '0;
            r_done      <= 1'b0;
            r_ferr      <= 1'b0;
            r_tmo       <= 1'b0;
            r_cerr      <= 1'b0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_nsym_vld <= 1'b0;
            r_done     <= 1'b0;
            r_ferr     <= 1'b0;
            r_tmo      <= 1'b0;
            r_cerr     <= 1'b0;

            if (abort) begin
                r_state <= S_IDLE;
                r_gate  <= 1'b0;
            end else if (w_end) begin
                r_state <= S_DONE;
                r_gate  <= 1'b0;
                if (w_end_ok) begin
                    r_done      <= 1'b1;
                    r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                end else begin
                    r_ferr      <= 1'b1;
                    r_err_cnt   <= r_err_cnt + CNT_W'(1);
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (arm) begin
                            if (w_cfg_ok) begin
                                r_nsym     <= cfg_num_symbols;
                                r_nsym_vld <= 1'b1;
                                r_len      <= SW'(cfg_num_symbols) * SW'(SYMBOL_LEN);
                                r_timeout  <= cfg_timeout;
                                r_cont     <= cfg_continuous;
                                r_state    <= S_CONFIG;
                            end else begin
                                r_cerr     <= 1'b1;
                            end
                        end
                    end
                    S_CONFIG: begin
                        r_state   <= S_SEARCH;
                        r_gate    <= 1'b1;
                        r_tmo_cnt <= '0;
                    end
                    S_SEARCH: begin
                        if (w_beat && mon_sof) begin
                            r_state   <= S_FRAME;
                            r_smp_cnt <= SW'(1);
                        end else if (w_tmo_hit) begin
                            r_tmo     <= 1'b1;
                            r_err_cnt <= r_err_cnt + CNT_W'(1);
                            r_tmo_cnt <= '0;
                            if (!r_cont) begin
                                r_state <= S_IDLE;
                                r_gate  <= 1'b0;
                            end
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + TIMEOUT_W'(1);
                        end
                    end
                    S_FRAME: begin
                        if (w_beat) begin
                            r_smp_cnt <= w_smp_next;
                        end
                    end
                    S_DONE: begin
                        if (r_cont) begin
                            r_state   <= S_SEARCH;
                            r_gate    <= 1'b1;
                            r_tmo_cnt <= '0;
                        end else begin
                            r_state   <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_gate  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sync_num_symbols       = r_nsym;
    assign sync_num_symbols_valid = r_nsym_vld;
    assign busy                   = (r_state != S_IDLE);
    assign m_tvalid               = s_tvalid & r_gate;
    assign s_tready               = m_tready & r_gate;
    assign frame_done             = r_done;
    assign frame_err              = r_ferr;
    assign timeout                = r_tmo;
    assign cfg_err                = r_cerr;
    assign frame_cnt              = r_frame_cnt;
    assign err_cnt                = r_err_cnt;

endmodule

// File: tb/tb_ofdm_sync_ctrl.sv
// Randomized self-checking bench for ofdm_sync_ctrl; expected timings and
// outcomes come from frame-level arithmetic on the requested symbol count.
module tb_ofdm_sync_ctrl;

    logic        clk;
    logic        reset_n;
    logic [3:0]  cfg_num_symbols;
    logic [23:0] cfg_timeout;
    logic        cfg_continuous;
    logic        arm;
    logic        abort;
    logic [3:0]  sync_num_symbols;
    logic        sync_num_symbols_valid;
    logic        s_tvalid;
    logic        s_tready;
    logic        m_tvalid;
    logic        m_tready;
    logic        mon_tvalid;
    logic        mon_tready;
    logic        mon_sof;
    logic        mon_eof;
    logic        busy;
    logic        frame_done;
    logic        frame_err;
    logic        timeout;
    logic        cfg_err;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_frames = '0;
    logic [15:0] exp_errs   = '0;

    ofdm_sync_ctrl #(
        .MAX_NUM_SYMBOLS (10),
        .SYMBOL_LEN      (64),
        .TIMEOUT_W       (24),
        .CNT_W           (16)
    ) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .cfg_num_symbols        (cfg_num_symbols),
        .cfg_timeout            (cfg_timeout),
        .cfg_continuous         (cfg_continuous),
        .arm                    (arm),
        .abort                  (abort),
        .sync_num_symbols       (sync_num_symbols),
        .sync_num_symbols_valid (sync_num_symbols_valid),
        .s_tvalid               (s_tvalid),
        .s_tready               (s_tready),
        .m_tvalid               (m_tvalid),
        .m_tready               (m_tready),
        .mon_tvalid             (mon_tvalid),
        .mon_tready             (mon_tready),
        .mon_sof                (mon_sof),
        .mon_eof                (mon_eof),
        .busy                   (busy),
        .frame_done             (frame_done),
        .frame_err              (frame_err),
        .timeout                (timeout),
        .cfg_err                (cfg_err),
        .frame_cnt              (frame_cnt),
        .err_cnt                (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mon_idle();
        mon_tvalid = 1'b0;
        mon_tready = 1'b0;
        mon_sof    = 1'b0;
        mon_eof    = 1'b0;
    endtask

    // Drives random beats until beat number end_beat has been accepted.
    task automatic send_beats(input int first, input int end_beat, input int eof_beat,
                              output int spurious);
        int   beats;
        int   guard;
        logic b;
        beats    = first - 1;
        guard    = 0;
        spurious = 0;
        while (beats < end_beat && guard < 4000) begin
            guard++;
            mon_tvalid = ($urandom_range(0, 3) != 0);
            mon_tready = ($urandom_range(0, 3) != 0);
            b = mon_tvalid & mon_tready;
            if (b) begin
                beats++;
                mon_sof = (beats == 1);
                mon_eof = (beats == eof_beat);
            end else begin
                mon_sof = 1'($urandom_range(0, 1));
                mon_eof = 1'($urandom_range(0, 1));
            end
            arm             = ($urandom_range(0, 7) == 0);
            cfg_num_symbols = 4'($urandom_range(0, 15));
            cfg_continuous  = 1'($urandom_range(0, 1));
            cfg_timeout     = 24'($urandom_range(1, 5));
            tick();
            if (beats < end_beat)
                spurious += int'(frame_done) + int'(frame_err) + int'(timeout) + int'(cfg_err);
        end
        mon_idle();
        arm = 1'b0;
        check("beat_budget", 32'(beats == end_beat), 1);
    endtask

    task automatic check_end(input logic ok, input logic cont);
        if (ok) exp_frames++;
        else    exp_errs++;
        check("frame_done", frame_done, ok);
        check("frame_err", frame_err, !ok);
        check("frame_cnt", frame_cnt, exp_frames);
        check("err_cnt", err_cnt, exp_errs);
        check("gate_in_done", s_tready, 0);
        tick();
        check("pulse_one_cycle", {frame_done, frame_err}, 0);
        check("busy_after_done", busy, cont);
        check("gate_after_done", s_tready, cont);
        if (cont) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check("abort_idle", {busy, s_tready, frame_done, frame_err, timeout}, 0);
        end
    endtask

    task automatic arm_valid(input int n, input int tmo, input logic cont);
        cfg_num_symbols = 4'(n);
        cfg_timeout     = 24'(tmo);
        cfg_continuous  = cont;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        cfg_timeout = 24'($urandom_range(1, 1000));
        check("load_strobe", sync_num_symbols_valid, 1);
        check("load_value", sync_num_symbols, n);
        check("gate_in_config", s_tready, 0);
    endtask

    task automatic run_frame(input int n, input int eof_beat, input logic cont);
        int   len;
        int   end_beat;
        int   sp;
        logic ok;
        len      = n * 64;
        end_beat = (eof_beat >= 1 && eof_beat <= len) ? eof_beat : len + 1;
        ok       = (eof_beat == len);
        arm_valid(n, 0, cont);
        tick();
        check("load_strobe_off", sync_num_symbols_valid, 0);
        check("gate_search", {busy, s_tready}, 2'b11);
        send_beats(1, end_beat, eof_beat, sp);
        check("no_early_pulse", sp, 0);
        check_end(ok, cont);
    endtask

    task automatic run_timeout(input int t, input logic cont, input int npulses);
        int k;
        mon_idle();
        arm_valid($urandom_range(1, 10), t, cont);
        for (int p = 0; p < npulses; p++) begin
            k = 0;
            do begin
                tick();
                k++;
            end while (!timeout && k < t + 5);
            check(p == 0 ? "tmo_first" : "tmo_period", k, p == 0 ? t + 1 : t);
            exp_errs++;
            check("tmo_err_cnt", err_cnt, exp_errs);
            check("tmo_busy", busy, cont);
        end
        if (cont) begin
            repeat (t - 1) tick();
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check("abort_no_tmo", {busy, timeout, s_tready}, 0);
            check("abort_err_cnt", err_cnt, exp_errs);
        end
    endtask

    task automatic bad_arm(input int v);
        cfg_num_symbols = 4'(v);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("cfg_err", cfg_err, 1);
        check("cfg_err_no_load", {sync_num_symbols_valid, busy}, 0);
        tick();
        check("cfg_err_one_cycle", cfg_err, 0);
    endtask

    task automatic sof_on_timeout();
        int t;
        int n;
        int sp;
        t = $urandom_range(4, 40);
        n = $urandom_range(1, 10);
        mon_idle();
        arm_valid(n, t, 1'b0);
        repeat (t) tick();
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
        mon_sof    = 1'b1;
        tick();
        mon_idle();
        check("sof_beats_tmo", timeout, 0);
        check("sof_enters_frame", busy, 1);
        check("sof_err_cnt", err_cnt, exp_errs);
        m_tready = 1'b0;
        #1;
        check("stall_s_tready", s_tready, 0);
        check("gate_m_tvalid", m_tvalid, 1);
        m_tready = 1'b1;
        #1;
        check("unstall_s_tready", s_tready, 1);
        send_beats(2, n * 64, n * 64, sp);
        check("no_early_pulse", sp, 0);
        check_end(1'b1, 1'b0);
    endtask

    initial begin
        int n;
        int mode;
        int len;
        int e;
        int sp;
        reset_n         = 1'b0;
        cfg_num_symbols = '0;
        cfg_timeout     = '0;
        cfg_continuous  = 1'b0;
        arm             = 1'b0;
        abort           = 1'b0;
        s_tvalid        = 1'b1;
        m_tready        = 1'b1;
        mon_idle();
        repeat (3) @(posedge clk);
        #1;
        check("rst_flags", {busy, frame_done, frame_err, timeout, cfg_err, sync_num_symbols_valid}, 0);
        check("rst_cnts", {frame_cnt, err_cnt}, 0);
        check("rst_gate", {s_tready, m_tvalid}, 0);
        check("rst_nsym", sync_num_symbols, 0);
        reset_n = 1'b1;
        tick();

        run_frame(2, 128, 1'b0);
        run_frame(2, 100, 1'b0);
        run_frame(2, 0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            n    = $urandom_range(1, 10);
            len  = n * 64;
            mode = $urandom_range(0, 3);
            case (mode)
                0:       e = len;
                1:       e = $urandom_range(1, len - 1);
                2:       e = 0;
                default: e = len;
            endcase
            run_frame(n, e, 1'($urandom_range(0, 1)));
        end

        run_timeout(50, 1'b1, 4);
        run_timeout($urandom_range(2, 30), 1'b0, 1);
        run_timeout($urandom_range(2, 30), 1'b1, 3);

        bad_arm(0);
        bad_arm(11);
        bad_arm($urandom_range(11, 15));

        cfg_num_symbols = 4'd3;
        arm   = 1'b1;
        abort = 1'b1;
        tick();
        arm   = 1'b0;
        abort = 1'b0;
        check("abort_beats_arm", {busy, sync_num_symbols_valid, cfg_err}, 0);

        sof_on_timeout();

        arm_valid(2, 0, 1'b0);
        tick();
        send_beats(1, 100, 0, sp);
        check("no_early_pulse", sp, 0);
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst_flags", {busy, frame_done, frame_err, timeout, sync_num_symbols_valid}, 0);
        check("midrst_gate", {s_tready, m_tvalid}, 0);
        check("midrst_cnts", {frame_cnt, err_cnt}, 0);
        check("midrst_nsym", sync_num_symbols, 0);
        exp_frames = '0;
        exp_errs   = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        check("post_rst_idle", busy, 0);

        run_frame(1, 64, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
